sspi_rx_avg: RTL and testbench
==============================

SSPI_RX_AVG -- requirements
Module: sspi_rx_avg

Interface
REQ-001 Parameter TCQ, default 0.1, register clock-to-q simulation delay.
REQ-002 Parameter CH_WIDTH, default 24, width of each channel (A = data[47:24], B = data[23:0]).
REQ-003 Parameter AVG_RATE, default 7, log2 of the averaging window (window = 128 samples).
REQ-004 clk_i  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 clear_i  in  1  synchronous clear of window state, one-cycle pulse.
REQ-007 sspi_rd_vld_i  in  1  one-cycle strobe marking a new slave-SPI word.
REQ-008 sspi_rd_data_i  in  2*CH_WIDTH  slave-SPI word, sampled when sspi_rd_vld_i=1.
REQ-009 ds_rate_i  in  10  down-sample ratio minus one, applied to averaged outputs.
REQ-010 avg_vld_o  out  1  one-cycle strobe for a new averaged word.
REQ-011 avg_data_o  out  2*CH_WIDTH  {avg_A, avg_B}, held between strobes.
REQ-012 ds_vld_o  out  1  one-cycle strobe for a down-sampled averaged word.
REQ-013 ds_data_o  out  2*CH_WIDTH  down-sampled word, held between strobes.
REQ-014 win_full_o  out  1  window holds 2^AVG_RATE valid samples.
REQ-015 overrun_o  out  1  sticky flag: an input strobe arrived too close to the previous one.

Function
REQ-016 The block SHALL keep a circular history of the last 2^AVG_RATE input words, indexed by write pointer wr_ptr (AVG_RATE bits), which wraps from 2^AVG_RATE-1 to 0.
REQ-017 The block SHALL keep one unsigned running sum per channel, CH_WIDTH+AVG_RATE bits wide, that never overflows.
REQ-018 On an accepted strobe with win_full_o=0, the sum SHALL be sum+new and the sample SHALL be written at wr_ptr.
REQ-019 On an accepted strobe with win_full_o=1, the sum SHALL be sum+new-history[wr_ptr], and the sample SHALL overwrite the oldest entry.
REQ-020 win_full_o SHALL rise in the cycle after the 2^AVG_RATE-th accepted sample and stay high until clear_i or reset.
REQ-021 avg_vld_o SHALL pulse exactly 2 cycles after each accepted strobe whose sample is the 2^AVG_RATE-th or later; no pulse SHALL be produced before that.
REQ-022 avg_data_o SHALL equal {sum_A[MSB:AVG_RATE], sum_B[MSB:AVG_RATE]} (truncating divide) and update only with avg_vld_o.
REQ-023 A down-sample counter SHALL increment on each avg_vld_o; when counter >= ds_rate_i, ds_vld_o SHALL pulse together with avg_vld_o, ds_data_o SHALL take avg_data_o, and the counter SHALL return to 0.
REQ-024 With ds_rate_i=0, ds_vld_o SHALL equal avg_vld_o; lowering ds_rate_i below the current count SHALL fire on the next avg_vld_o with no counter wrap.
REQ-025 Input strobes SHALL be at least 4 cycles apart. A strobe arriving within 3 cycles of the last accepted strobe SHALL be dropped and SHALL set overrun_o.
REQ-026 clear_i SHALL zero the sums, wr_ptr, win_full_o, the down-sample counter, overrun_o and the pipeline valids. A strobe in the same cycle as clear_i SHALL be dropped. History contents need not be cleared.
REQ-027 The internal state machine SHALL have states IDLE -> RD_OLD (read history[wr_ptr]) -> ACC (update sum, write history, advance wr_ptr) -> OUT (issue strobes) -> IDLE; clear_i from any state SHALL return it to IDLE.

Reset
REQ-028 Asserting rst_n_i=0 SHALL asynchronously force all registers, sums, counters and outputs to 0 and the state to IDLE, including when a sample is in flight; the first output after release SHALL again require 2^AVG_RATE samples.
REQ-029 History RAM contents SHALL NOT be reset.

Structure
REQ-030 A shared package SHALL hold the state encodings (IDLE, RD_OLD, ACC, OUT), the minimum strobe spacing constant (4) and the channel split indices.
REQ-031 The history SHALL be a single sub-module, sdp_ram_sync: simple dual-port, 2^AVG_RATE x 2*CH_WIDTH, registered read, no reset.

Verification
REQ-032 128 strobes of 0x000064_0000C8 at 48-cycle spacing -> exactly one avg_vld_o, 2 cycles after the 128th strobe; avg_data_o=0x000064_0000C8; win_full_o=1.
REQ-033 Continue with 128 strobes of 0x0000C8_000000 -> the averages ramp; the 128th output is 0x0000C8_000000; sum_A never exceeds 31 bits.
REQ-034 Window full, ds_rate_i=3, 12 strobes -> ds_vld_o on the 4th, 8th and 12th avg_vld_o; ds_rate_i changed to 1 at count 2 -> fire on the next avg_vld_o.
REQ-035 Two strobes 2 cycles apart -> the second is dropped, overrun_o=1 and sticky, the sum is unchanged; clear_i -> overrun_o=0.
REQ-036 rst_n_i pulsed low mid-ACC after 200 samples -> all outputs 0 immediately, and the next avg_vld_o only after 128 new samples.
REQ-037 clear_i coincident with a strobe on a full window -> the strobe is dropped, win_full_o=0, and no avg_vld_o for the next 127 strobes.

Source files
------------

// File: rtl/sspi_rx_avg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sspi_rx_avg_pkg
//  Purpose  : Shared definitions for the slave-SPI moving-average receiver:
//             state encodings, the minimum input strobe spacing and the
//             position of each channel inside a received word.
//  Revision : 1.0 - initial release
// ============================================================================
package sspi_rx_avg_pkg;

    // One accepted sample walks through all four states. Strobes seen outside
    // IDLE are therefore closer together than the minimum spacing.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // waiting for a strobe
        ST_RD_OLD = 2'd1,  // registered read of history[wr_ptr]
        ST_ACC    = 2'd2,  // update sums, write history, advance pointer
        ST_OUT    = 2'd3   // averaged / down-sampled strobes are visible
    } state_t;

    // Minimum distance, in clock cycles, between two accepted strobes.
    localparam int c_MIN_STROBE_SPACING = 4;

    // Channel slot inside a 2*CH_WIDTH word: A is the upper half, B the lower.
    localparam int c_CH_A_IDX = 1;
    localparam int c_CH_B_IDX = 0;

    // Width of the down-sample ratio input and counter.
    localparam int c_DS_RATE_W = 10;

    // LSB position of channel slot idx for a given channel width.
    function automatic int ch_lsb(input int idx, input int ch_width);
        return idx * ch_width;
    endfunction

endpackage : sspi_rx_avg_pkg
`default_nettype wire

// File: rtl/sspi_rx_avg_ram.sv
`default_nettype none
// ============================================================================
//  Module   : sdp_ram_sync
//  Purpose  : Simple dual-port RAM, one write port and one registered read
//             port on the same clock. Contents are never reset.
//  Ports    : clk_i      - clock
//             wr_en_i    - write enable
//             wr_addr_i  - write address
//             wr_data_i  - write data
//             rd_en_i    - read enable; rd_data_o updates on the next edge
//             rd_addr_i  - read address
//             rd_data_o  - registered read data, held when rd_en_i=0
//  Revision : 1.0 - initial release
// ============================================================================
module sdp_ram_sync #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 48
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] r_mem [1 << ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule : sdp_ram_sync
`default_nettype wire

// File: rtl/sspi_rx_avg.sv
`default_nettype none
// ============================================================================
//  Module   : sspi_rx_avg
//  Purpose  : Moving average over the last 2^AVG_RATE slave-SPI words, two
//             independent CH_WIDTH channels per word, with an optional
//             down-sampled copy of the averaged stream.
//  Timing   : a strobe is accepted on the clock edge that samples it; the
//             matching avg_vld_o pulse is visible two cycles after that edge
//             (FSM state OUT), for the 2^AVG_RATE-th sample and every later one.
//  Ports    : clk_i          - system clock, rising edge
//             rst_n_i        - asynchronous active-low reset
//             clear_i        - synchronous clear of window state (pulse)
//             sspi_rd_vld_i  - one-cycle strobe for a new input word
//             sspi_rd_data_i - input word {A, B}
//             ds_rate_i      - down-sample ratio minus one
//             avg_vld_o      - averaged word strobe
//             avg_data_o     - {avg_A, avg_B}, held between strobes
//             ds_vld_o       - down-sampled word strobe
//             ds_data_o      - down-sampled word, held between strobes
//             win_full_o     - window holds 2^AVG_RATE samples
//             overrun_o      - sticky: a strobe arrived too early and was lost
//  Revision : 1.0 - initial release
// ============================================================================
module sspi_rx_avg
    import sspi_rx_avg_pkg::*;
#(
    parameter real TCQ      = 0.1,
    parameter int  CH_WIDTH = 24,
    parameter int  AVG_RATE = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clear_i,
    input  logic                   sspi_rd_vld_i,
    input  logic [2*CH_WIDTH-1:0]  sspi_rd_data_i,
    input  logic [c_DS_RATE_W-1:0] ds_rate_i,
    output logic                   avg_vld_o,
    output logic [2*CH_WIDTH-1:0]  avg_data_o,
    output logic                   ds_vld_o,
    output logic [2*CH_WIDTH-1:0]  ds_data_o,
    output logic                   win_full_o,
    output logic                   overrun_o
);

    localparam int c_WORD_W = 2 * CH_WIDTH;
    localparam int c_SUM_W  = CH_WIDTH + AVG_RATE;
    localparam int c_GAP_W  = $clog2(c_MIN_STROBE_SPACING);
    localparam int c_A_LSB  = ch_lsb(c_CH_A_IDX, CH_WIDTH);
    localparam int c_B_LSB  = ch_lsb(c_CH_B_IDX, CH_WIDTH);

    // TCQ is a simulation clock-to-q figure for zero-delay flows; this RTL
    // applies no delay, so the parameter only appears at elaboration.
    if (TCQ < 0.0) begin : g_tcq_negative
    end

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_accept;
    logic                    w_ram_rd_en;
    logic                    w_ram_wr_en;

    logic [c_GAP_W-1:0]      r_gap_cnt;
    logic [c_WORD_W-1:0]     r_sample;
    logic                    r_overrun;

    logic [AVG_RATE-1:0]     r_wr_ptr;
    logic                    r_win_full;
    logic                    w_full_now;
    logic [c_SUM_W-1:0]      r_sum_a;
    logic [c_SUM_W-1:0]      r_sum_b;
    logic [c_SUM_W-1:0]      w_old_a;
    logic [c_SUM_W-1:0]      w_old_b;
    logic [c_SUM_W-1:0]      w_sum_a_nxt;
    logic [c_SUM_W-1:0]      w_sum_b_nxt;
    logic [c_WORD_W-1:0]     w_old_word;
    logic [c_WORD_W-1:0]     w_avg_word;

    logic                    r_avg_vld;
    logic [c_WORD_W-1:0]     r_avg_data;
    logic                    r_ds_vld;
    logic [c_WORD_W-1:0]     r_ds_data;
    logic [c_DS_RATE_W-1:0]  r_ds_cnt;

    // A strobe is taken only when the previous sample has fully retired and
    // the spacing counter has expired; a strobe alongside clear_i is lost.
    assign w_accept = sspi_rd_vld_i && !clear_i &&
                      (r_state == ST_IDLE) && (r_gap_cnt == '0);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ram_rd_en  = 1'b0;
        w_ram_wr_en  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_RD_OLD;
                end
            end
            ST_RD_OLD: begin
                w_ram_rd_en  = 1'b1;
                w_next_state = ST_ACC;
            end
            ST_ACC: begin
                w_ram_wr_en  = !clear_i;
                w_next_state = ST_OUT;
            end
            ST_OUT: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (clear_i) begin
            w_next_state = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Input capture, spacing guard and overrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_gap_cnt <= '0;
            r_sample  <= '0;
            r_overrun <= 1'b0;
        end else if (clear_i) begin
            r_gap_cnt <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sample  <= sspi_rd_data_i;
                r_gap_cnt <= c_GAP_W'(c_MIN_STROBE_SPACING - 1);
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
            end
            if (sspi_rd_vld_i && !w_accept) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Running sums
    // ------------------------------------------------------------------
    always_comb begin
        // The sample being written at the last slot completes the window.
        w_full_now = r_win_full | (&r_wr_ptr);
        // Until the window is full the history slot holds no live sample.
        w_old_a = '0;
        w_old_b = '0;
        if (r_win_full) begin
            w_old_a = c_SUM_W'(w_old_word[c_A_LSB +: CH_WIDTH]);
            w_old_b = c_SUM_W'(w_old_word[c_B_LSB +: CH_WIDTH]);
        end
        // Modulo arithmetic: sum+new may wrap transiently but the result,
        // never larger than 2^AVG_RATE full-scale samples, always fits.
        w_sum_a_nxt = r_sum_a + c_SUM_W'(r_sample[c_A_LSB +: CH_WIDTH]) - w_old_a;
        w_sum_b_nxt = r_sum_b + c_SUM_W'(r_sample[c_B_LSB +: CH_WIDTH]) - w_old_b;
        // Truncating divide by the window length.
        w_avg_word = '0;
        w_avg_word[c_A_LSB +: CH_WIDTH] = w_sum_a_nxt[c_SUM_W-1 -: CH_WIDTH];
        w_avg_word[c_B_LSB +: CH_WIDTH] = w_sum_b_nxt[c_SUM_W-1 -: CH_WIDTH];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sum_a    <= '0;
            r_sum_b    <= '0;
            r_wr_ptr   <= '0;
            r_win_full <= 1'b0;
        end else if (clear_i) begin
            r_sum_a    <= '0;
            r_sum_b    <= '0;
            r_wr_ptr   <= '0;
            r_win_full <= 1'b0;
        end else if (w_ram_wr_en) begin
            r_sum_a  <= w_sum_a_nxt;
            r_sum_b  <= w_sum_b_nxt;
            r_wr_ptr <= r_wr_ptr + AVG_RATE'(1);
            if (&r_wr_ptr) begin
                r_win_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Averaged and down-sampled outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_avg_vld  <= 1'b0;
            r_avg_data <= '0;
            r_ds_vld   <= 1'b0;
            r_ds_data  <= '0;
            r_ds_cnt   <= '0;
        end else begin
            r_avg_vld <= 1'b0;
            r_ds_vld  <= 1'b0;
            if (clear_i) begin
                r_ds_cnt <= '0;
            end else if (w_ram_wr_en && w_full_now) begin
                r_avg_vld  <= 1'b1;
                r_avg_data <= w_avg_word;
                // ">=" rather than "==" so a ratio lowered below the current
                // count fires on the next average instead of wrapping.
                if (r_ds_cnt >= ds_rate_i) begin
                    r_ds_vld  <= 1'b1;
                    r_ds_data <= w_avg_word;
                    r_ds_cnt  <= '0;
                end else begin
                    r_ds_cnt <= r_ds_cnt + c_DS_RATE_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // History of the last 2^AVG_RATE words
    // ------------------------------------------------------------------
    sdp_ram_sync #(
        .ADDR_W (AVG_RATE),
        .DATA_W (c_WORD_W)
    ) u_hist (
        .clk_i     (clk_i),
        .wr_en_i   (w_ram_wr_en),
        .wr_addr_i (r_wr_ptr),
        .wr_data_i (r_sample),
        .rd_en_i   (w_ram_rd_en),
        .rd_addr_i (r_wr_ptr),
        .rd_data_o (w_old_word)
    );

    assign avg_vld_o  = r_avg_vld;
    assign avg_data_o = r_avg_data;
    assign ds_vld_o   = r_ds_vld;
    assign ds_data_o  = r_ds_data;
    assign win_full_o = r_win_full;
    assign overrun_o  = r_overrun;

endmodule : sspi_rx_avg
`default_nettype wire

// File: tb/tb_sspi_rx_avg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sspi_rx_avg
//  Purpose  : Directed self-checking bench for sspi_rx_avg. Table-driven
//             vectors for the averaging ramp and the down-sampler, plus
//             hand-written sequences for overrun, clear and reset corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sspi_rx_avg;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        clear_i;
    logic        sspi_rd_vld_i;
    logic [47:0] sspi_rd_data_i;
    logic [9:0]  ds_rate_i;
    logic        avg_vld_o;
    logic [47:0] avg_data_o;
    logic        ds_vld_o;
    logic [47:0] ds_data_o;
    logic        win_full_o;
    logic        overrun_o;

    always #5 clk = ~clk;

    sspi_rx_avg dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n_i),
        .clear_i        (clear_i),
        .sspi_rd_vld_i  (sspi_rd_vld_i),
        .sspi_rd_data_i (sspi_rd_data_i),
        .ds_rate_i      (ds_rate_i),
        .avg_vld_o      (avg_vld_o),
        .avg_data_o     (avg_data_o),
        .ds_vld_o       (ds_vld_o),
        .ds_data_o      (ds_data_o),
        .win_full_o     (win_full_o),
        .overrun_o      (overrun_o)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_avg_pulses = 0;

    // Counts every avg_vld_o pulse, whatever the sequence in progress.
    always @(posedge clk) begin
        if (avg_vld_o === 1'b1) n_avg_pulses++;
    end

    typedef struct {
        int          k;        // strobe index within the ramp
        logic [47:0] exp_avg;  // expected avg_data_o after that strobe
    } ramp_vec_t;

    typedef struct {
        logic [9:0]  rate;     // ds_rate_i applied for this strobe
        logic        exp_ds;   // expected ds_vld_o alongside avg_vld_o
    } ds_vec_t;

    ramp_vec_t ramp_tbl[5];
    ds_vec_t   ds_tbl[17];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called on a negedge. Drives one strobe, checks that avg_vld_o pulses
    // exactly two cycles after the sampling edge (or not at all), and
    // returns ds_vld_o / win_full_o seen alongside that slot.
    task automatic strobe(input logic [47:0] d, input logic exp_pulse, input int gap,
                          output logic ds_seen, output logic full_seen);
        sspi_rd_vld_i  = 1'b1;
        sspi_rd_data_i = d;
        @(negedge clk);
        sspi_rd_vld_i  = 1'b0;
        @(negedge clk);
        chk("avg_vld_early", {47'd0, avg_vld_o}, 48'd0);
        @(negedge clk);
        chk("avg_vld_slot", {47'd0, avg_vld_o}, {47'd0, exp_pulse});
        ds_seen   = ds_vld_o;
        full_seen = win_full_o;
        @(negedge clk);
        chk("avg_vld_late", {47'd0, avg_vld_o}, 48'd0);
        repeat (gap - 4) @(negedge clk);
    endtask

    initial begin
        logic ds_s;
        logic full_s;
        int   base;

        ramp_tbl[0] = '{1,   48'h000064_0000C6};
        ramp_tbl[1] = '{2,   48'h000065_0000C4};
        ramp_tbl[2] = '{64,  48'h000096_000064};
        ramp_tbl[3] = '{127, 48'h0000C7_000001};
        ramp_tbl[4] = '{128, 48'h0000C8_000000};

        for (int i = 0; i < 12; i++) ds_tbl[i] = '{10'd3, ((i % 4) == 3)};
        ds_tbl[12] = '{10'd3, 1'b0};
        ds_tbl[13] = '{10'd3, 1'b0};
        ds_tbl[14] = '{10'd1, 1'b1};   // lowered below the count of 2
        ds_tbl[15] = '{10'd1, 1'b0};
        ds_tbl[16] = '{10'd1, 1'b1};

        // ---------------- reset state ----------------
        rst_n_i        = 1'b0;
        clear_i        = 1'b0;
        sspi_rd_vld_i  = 1'b0;
        sspi_rd_data_i = '0;
        ds_rate_i      = '0;
        repeat (3) @(negedge clk);
        chk("rst_avg_vld",  {47'd0, avg_vld_o},  48'd0);
        chk("rst_avg_data", avg_data_o,          48'd0);
        chk("rst_ds_vld",   {47'd0, ds_vld_o},   48'd0);
        chk("rst_ds_data",  ds_data_o,           48'd0);
        chk("rst_win_full", {47'd0, win_full_o}, 48'd0);
        chk("rst_overrun",  {47'd0, overrun_o},  48'd0);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- first window, 48-cycle spacing ----------------
        base = n_avg_pulses;
        for (int k = 1; k <= 128; k++) begin
            strobe(48'h000064_0000C8, (k == 128), 48, ds_s, full_s);
            if (k >= 127) chk("fill_win_full", {47'd0, full_s}, {47'd0, (k == 128)});
        end
        chk("fill_pulse_count", 48'(n_avg_pulses - base), 48'd1);
        chk("fill_avg_data", avg_data_o, 48'h000064_0000C8);
        chk("fill_ds_data",  ds_data_o,  48'h000064_0000C8);

        // ---------------- ramp towards a new level ----------------
        for (int k = 1; k <= 128; k++) begin
            strobe(48'h0000C8_000000, 1'b1, 5, ds_s, full_s);
            for (int t = 0; t < 5; t++) begin
                if (ramp_tbl[t].k == k) chk($sformatf("ramp_avg_k%0d", k), avg_data_o, ramp_tbl[t].exp_avg);
            end
        end

        // ---------------- down-sampler ----------------
        for (int i = 0; i < 17; i++) begin
            ds_rate_i = ds_tbl[i].rate;
            strobe(48'h0000C8_000000, 1'b1, 5, ds_s, full_s);
            chk($sformatf("ds_vld_%0d", i), {47'd0, ds_s}, {47'd0, ds_tbl[i].exp_ds});
            if (ds_tbl[i].exp_ds) chk($sformatf("ds_data_%0d", i), ds_data_o, 48'h0000C8_000000);
        end
        ds_rate_i = '0;

        // ---------------- overrun: strobes two cycles apart ----------------
        base = n_avg_pulses;
        sspi_rd_vld_i  = 1'b1;
        sspi_rd_data_i = 48'h0000C8_000000;
        @(negedge clk);
        sspi_rd_vld_i  = 1'b0;
        @(negedge clk);
        chk("ovr_before", {47'd0, overrun_o}, 48'd0);
        sspi_rd_vld_i  = 1'b1;
        sspi_rd_data_i = 48'hFFFFFF_FFFFFF;
        @(negedge clk);
        sspi_rd_vld_i  = 1'b0;
        chk("ovr_set", {47'd0, overrun_o}, 48'd1);
        chk("ovr_first_pulse", {47'd0, avg_vld_o}, 48'd1);
        chk("ovr_first_avg", avg_data_o, 48'h0000C8_000000);
        repeat (6) @(negedge clk);
        chk("ovr_pulse_count", 48'(n_avg_pulses - base), 48'd1);
        strobe(48'h0000C8_000000, 1'b1, 5, ds_s, full_s);
        chk("ovr_sum_unchanged", avg_data_o, 48'h0000C8_000000);
        chk("ovr_sticky", {47'd0, overrun_o}, 48'd1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("ovr_cleared", {47'd0, overrun_o}, 48'd0);
        chk("clr_win_full", {47'd0, win_full_o}, 48'd0);
        repeat (2) @(negedge clk);

        // ---------------- clear coincident with a strobe ----------------
        for (int k = 1; k <= 128; k++) strobe(48'h000010_000020, (k == 128), 5, ds_s, full_s);
        chk("refill_avg", avg_data_o, 48'h000010_000020);
        chk("refill_full", {47'd0, win_full_o}, 48'd1);
        base = n_avg_pulses;
        clear_i        = 1'b1;
        sspi_rd_vld_i  = 1'b1;
        sspi_rd_data_i = 48'h000030_000040;
        @(negedge clk);
        clear_i       = 1'b0;
        sspi_rd_vld_i = 1'b0;
        chk("clrstb_win_full", {47'd0, win_full_o}, 48'd0);
        repeat (5) @(negedge clk);
        chk("clrstb_no_pulse", 48'(n_avg_pulses - base), 48'd0);
        for (int k = 1; k <= 128; k++) strobe(48'h000030_000040, (k == 128), 5, ds_s, full_s);
        chk("clrstb_pulse_count", 48'(n_avg_pulses - base), 48'd1);
        chk("clrstb_avg", avg_data_o, 48'h000030_000040);

        // ---------------- reset mid-ACC after 200 samples ----------------
        for (int k = 1; k <= 200; k++) strobe(48'h000030_000040, 1'b1, 5, ds_s, full_s);
        sspi_rd_vld_i  = 1'b1;
        sspi_rd_data_i = 48'h000050_000060;
        @(negedge clk);
        sspi_rd_vld_i  = 1'b0;
        @(negedge clk);
        rst_n_i = 1'b0;
        #1;
        chk("arst_avg_vld",  {47'd0, avg_vld_o},  48'd0);
        chk("arst_avg_data", avg_data_o,          48'd0);
        chk("arst_ds_vld",   {47'd0, ds_vld_o},   48'd0);
        chk("arst_ds_data",  ds_data_o,           48'd0);
        chk("arst_win_full", {47'd0, win_full_o}, 48'd0);
        chk("arst_overrun",  {47'd0, overrun_o},  48'd0);
        @(negedge clk);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk);
        base = n_avg_pulses;
        for (int k = 1; k <= 128; k++) strobe(48'h000050_000060, (k == 128), 5, ds_s, full_s);
        chk("arst_pulse_count", 48'(n_avg_pulses - base), 48'd1);
        chk("arst_new_avg", avg_data_o, 48'h000050_000060);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_sspi_rx_avg
`default_nettype wire
